// File: rtl/mult_seq_mac.sv
// Sequential shift-and-add multiplier (one multiplier bit per clock) with optional
// signed/unsigned mode and a wrapping multiply-accumulate register.
module mult_seq_mac #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ACC_W = 2 * WIDTH + 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   input  logic                 acc_en,
   input  logic                 acc_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [ACC_W-1:0]     acc,
   output logic                 busy
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StBusy, StFinish, StDone} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  mcand_q;
   logic [PW-1:0]     psum_q;
   logic [CntW-1:0]   cnt_q;
   logic              neg_q;
   logic              sgn_q;
   logic              en_q;
   logic              clr_q;

   logic [WIDTH-1:0]  a_mag;
   logic [WIDTH-1:0]  b_mag;
   logic [WIDTH-1:0]  addend;
   logic [WIDTH:0]    step_sum;
   logic [PW-1:0]     prod_res;
   logic [ACC_W-1:0]  acc_x;

   always_comb begin
      // The most negative value negates to itself, which is the correct unsigned magnitude.
      a_mag    = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag    = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      // Upper half holds the partial sum, lower half the remaining multiplier bits.
      addend   = psum_q[0] ? mcand_q : '0;
      step_sum = {1'b0, psum_q[PW-1:WIDTH]} + {1'b0, addend};
      prod_res = neg_q ? (~psum_q + PW'(1)) : psum_q;
      acc_x    = sgn_q ? ACC_W'($signed(prod_res)) : ACC_W'(prod_res);
   end

   assign in_ready = (state_q == StIdle);
   assign busy     = (state_q != StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         psum_q    <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         sgn_q     <= 1'b0;
         en_q      <= 1'b0;
         clr_q     <= 1'b0;
         out_valid <= 1'b0;
         product   <= '0;
         acc       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  mcand_q <= a_mag;
                  psum_q  <= {{WIDTH{1'b0}}, b_mag};
                  cnt_q   <= '0;
                  neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  sgn_q   <= is_signed;
                  en_q    <= acc_en;
                  clr_q   <= acc_clr;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               psum_q <= {step_sum, psum_q[WIDTH-1:1]};
               cnt_q  <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  state_q <= StFinish;
               end
            end
            StFinish: begin
               product <= prod_res;
               unique case ({en_q, clr_q})
                  2'b11:   acc <= acc_x;
                  2'b10:   acc <= acc + acc_x;
                  2'b01:   acc <= '0;
                  default: acc <= acc;
               endcase
               out_valid <= 1'b1;
               state_q   <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_mac.sv
// Scoreboard bench for mult_seq_mac: driver pushes model results, monitor pops and
// compares whenever out_valid appears, and controls out_ready backpressure.
module tb_mult_seq_mac;

   localparam int unsigned W  = 16;
   localparam int unsigned AW = 40;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          is_signed;
   logic          acc_en;
   logic          acc_clr;
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] product;
   logic [AW-1:0] acc;
   logic          busy;

   mult_seq_mac #(.WIDTH(W), .ACC_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .acc       (acc),
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sg;
      logic         en;
      logic         clr;
      int           stall;
   } op_t;

   typedef struct {
      logic [2*W-1:0] prod;
      logic [AW-1:0]  acc;
      int             stall;
      longint         acyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] model_acc;
   longint        cyc = 0;
   int            checks = 0;
   int            errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
      end
   endtask

   // Reference model: plain integer multiply of the operands as interpreted by the mode.
   task automatic model(input op_t o, input longint acyc);
      longint pa, pb, pr;
      exp_t   e;
      pa = o.sg ? longint'($signed(o.a)) : longint'(o.a);
      pb = o.sg ? longint'($signed(o.b)) : longint'(o.b);
      pr = pa * pb;
      if (o.en && o.clr)      model_acc = pr[AW-1:0];
      else if (o.en)          model_acc = model_acc + pr[AW-1:0];
      else if (o.clr)         model_acc = '0;
      e.prod  = pr[2*W-1:0];
      e.acc   = model_acc;
      e.stall = o.stall;
      e.acyc  = acyc;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready(output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (!in_ready) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            chk("wait_in_ready_timeout", 1, 0);
            ok = 1'b0;
            return;
         end
      end
   endtask

   task automatic drive(input op_t o);
      a         = o.a;
      b         = o.b;
      is_signed = o.sg;
      acc_en    = o.en;
      acc_clr   = o.clr;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      // Garbage on the operand inputs must not disturb the operation in flight.
      a         = W'($urandom);
      b         = W'($urandom);
      is_signed = 1'($urandom);
      acc_en    = 1'($urandom);
      acc_clr   = 1'($urandom);
   endtask

   task automatic issue(input op_t o);
      bit ok;
      int n;
      wait_ready(ok);
      if (!ok) return;
      drive(o);
      model(o, cyc);
      n = 0;
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_low_cycles", n, 18 + o.stall);
   endtask

   // Monitor: 0 wait, 1 holding under backpressure, 2 just handshaken, 3 recover.
   initial begin
      int   mmode;
      int   stall_left;
      exp_t cur;
      mmode      = 0;
      stall_left = 0;
      out_ready  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mmode     = 0;
            out_ready = 1'b0;
         end else begin
            case (mmode)
               0: if (out_valid) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_out_valid", 1, 0);
                     out_ready = 1'b1;
                     mmode     = 3;
                  end else begin
                     cur = exp_q.pop_front();
                     chk("product", longint'(product), longint'(cur.prod));
                     chk("acc", longint'(acc), longint'(cur.acc));
                     chk("latency", cyc - cur.acyc, 17);
                     if (cur.stall == 0) begin
                        out_ready = 1'b1;
                        mmode     = 2;
                     end else begin
                        stall_left = cur.stall;
                        mmode      = 1;
                     end
                  end
               end
               1: begin
                  chk("held_out_valid", longint'(out_valid), 1);
                  chk("held_product", longint'(product), longint'(cur.prod));
                  chk("held_acc", longint'(acc), longint'(cur.acc));
                  chk("held_in_ready", longint'(in_ready), 0);
                  stall_left--;
                  if (stall_left == 0) begin
                     out_ready = 1'b1;
                     mmode     = 2;
                  end
               end
               2: begin
                  chk("post_hs_out_valid", longint'(out_valid), 0);
                  chk("post_hs_in_ready", longint'(in_ready), 1);
                  chk("post_hs_busy", longint'(busy), 0);
                  chk("post_hs_product", longint'(product), longint'(cur.prod));
                  chk("post_hs_acc", longint'(acc), longint'(cur.acc));
                  out_ready = 1'b0;
                  mmode     = 0;
               end
               default: begin
                  out_ready = 1'b0;
                  mmode     = 0;
               end
            endcase
         end
      end
   end

   initial begin
      op_t dir[$];
      op_t o;
      bit  ok;
      int  n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      is_signed = 1'b0;
      acc_en    = 1'b0;
      acc_clr   = 1'b0;
      model_acc = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_product", longint'(product), 0);
      chk("rst_acc", longint'(acc), 0);
      chk("rst_busy", longint'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", longint'(in_ready), 1);
      chk("rel_busy", longint'(busy), 0);

      dir = '{
         '{16'd3,     16'd5,     1'b0, 1'b0, 1'b0, 0},
         '{16'hFFFF,  16'hFFFF,  1'b0, 1'b0, 1'b0, 1},
         '{16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 1'b0, 0},
         '{16'h8000,  16'h8000,  1'b1, 1'b0, 1'b0, 2},
         '{16'h8000,  16'h0001,  1'b1, 1'b0, 1'b0, 0},
         '{16'h0000,  16'h1234,  1'b0, 1'b0, 1'b0, 0},
         '{16'd3,     16'd4,     1'b1, 1'b1, 1'b1, 0},
         '{16'd5,     16'hFFFE,  1'b1, 1'b1, 1'b0, 0},
         '{16'd7,     16'd9,     1'b1, 1'b0, 1'b1, 0},
         '{16'h1111,  16'h2222,  1'b0, 1'b0, 1'b0, 5},
         '{16'h8001,  16'h7FFF,  1'b1, 1'b1, 1'b1, 0},
         '{16'hABCD,  16'h1234,  1'b0, 1'b1, 1'b0, 3}
      };
      foreach (dir[i]) issue(dir[i]);

      // Abort an operation mid-multiply; acc is nonzero beforehand.
      wait_ready(ok);
      if (ok) begin
         o = '{16'h1234, 16'h0F0F, 1'b0, 1'b1, 1'b0, 0};
         drive(o);
         repeat (8) @(negedge clk);
         rst = 1'b1;
         #1;
         chk("abort_out_valid", longint'(out_valid), 0);
         chk("abort_acc", longint'(acc), 0);
         chk("abort_product", longint'(product), 0);
         chk("abort_busy", longint'(busy), 0);
         model_acc = '0;
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         chk("abort_in_ready", longint'(in_ready), 1);
      end

      for (int i = 0; i < 40; i++) begin
         o.a     = W'($urandom);
         o.b     = W'($urandom);
         o.sg    = 1'($urandom_range(0, 1));
         o.en    = ($urandom_range(0, 3) != 0);
         o.clr   = ($urandom_range(0, 5) == 0);
         o.stall = $urandom_range(0, 3);
         issue(o);
      end

      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("queue_drained", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
